instr_encode: RTL
=================

// Module: instr_encode
// PURPOSE
//  RV32I instruction encoder: packs opcode/register/funct/immediate fields into 32-bit words.
//  Field layout is the exact inverse of the CPU field decoder, so the decoder recovers every field unchanged.
//  A valid/ready input stream feeds a DEPTH-entry output FIFO.
//  Each word is stamped with an incrementing instruction-memory address. Used by the program loader and testbenches.
// PARAMETERS
//  DEPTH      2    output FIFO entries (>=2)
//  ADDR_W     32   width of out_addr
//  BASE_ADDR  0    address of first word after reset/restart
// PORTS
//  clk        in   1       clock (one clock domain)
//  rst        in   1       reset, synchronous, active-high
//  restart    in   1       sync: flush FIFO, next address = BASE_ADDR
//  in_valid   in   1       field tuple valid
//  in_ready   out  1       encoder can accept
//  in_fmt     in   3       0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
//  in_opcode  in   7       opcode
//  in_rd      in   5       destination register
//  in_rs1     in   5       source register 1
//  in_rs2     in   5       source register 2
//  in_funct3  in   3       funct3
//  in_funct7  in   7       funct7 (R only)
//  in_imm     in   20      immediate in decoder field order (I/S/B use [11:0], U/J use [19:0])
//  out_valid  out  1       FIFO head valid
//  out_ready  in   1       consumer accepts head
//  out_instr  out  32      encoded word at FIFO head
//  out_addr   out  ADDR_W  address stamped on head word
//  err_pulse  out  1       one-cycle pulse: illegal in_fmt was accepted
//  err_seen   out  1       sticky illegal-format flag, cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, next address = BASE_ADDR; in_ready=0 while rst is high.
//  in_ready = !rst && !restart && (count != DEPTH); registered count only, no out_ready->in_ready path.
//  Input accept = in_valid && in_ready. Encoding is combinational; the word is written into the FIFO the same edge.
//  Latency: out_valid rises 1 cycle after accept when the FIFO was empty.
//  Encoding (the unused fields of each format are ignored):
//   R {funct7,rs2,rs1,funct3,rd,op}
//   I {imm[11:0],rs1,funct3,rd,op}
//   S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}
//   B {imm[11],imm[9:4],rs2,rs1,funct3,imm[3:0],imm[10],op}  (imm = branch offset[12:1])
//   U {imm[19:0],rd,op}
//   J {imm[19],imm[9:0],imm[10],imm[18:11],rd,op}  (imm = jump offset[20:1])
//  Address: entry stamped with next address at enqueue; next address += 4, wrapping mod 2^ADDR_W.
//  Illegal fmt: tuple consumed (in_ready handshake completes), nothing enqueued, address unchanged.
//   err_pulse=1 next cycle; err_seen set.
//  Pop = out_valid && out_ready. Push and pop in the same cycle (count<DEPTH) are allowed; count unchanged.
//  Full: in_ready=0; held tuple is not lost; in_valid may stay high.
//  Empty: out_valid=0; out_instr/out_addr are don't-care (driven 0).
//  restart: priority over push/pop; FIFO emptied and next address = BASE_ADDR at that edge.
//   err_seen is kept; a pending err_pulse still fires.
//  rst mid-stream: same as restart, plus err_seen cleared.
//  FIFO order is strict; pointers wrap modulo DEPTH.
// STRUCTURE
//  Shared package: format codes FMT_R..FMT_J; RV32I opcode constants (OP_REG 0x33, OP_IMM 0x13, OP_BR 0x63, ...).
//  Sub-module rv_enc_pack: pure combinational field->word packer (reused by assembler-side tools).
//  The FIFO and address counter stay inline.
// TESTING
//  R add x3,x1,x2 (op 0x33,f3 0,f7 0), BASE 0 -> out_instr 0x002081B3, out_addr 0, 1-cycle latency.
//  I addi x1,x0,-1 (op 0x13, imm 0xFFF) -> 0xFFF00093; follows previous at out_addr 4.
//  B beq x1,x2,+8 (op 0x63, imm 0x004) -> 0x00208463; J jal x1,+8 (op 0x6F, imm 0x00004) -> 0x008000EF.
//  out_ready=0, push 3 tuples -> 2 accepted, in_ready=0, third held; out_ready=1 -> drain in order,
//   addr 0,4,8; simultaneous push/pop holds count.
//  in_fmt=7 -> err_pulse high exactly 1 cycle, err_seen=1, no out_valid, next legal word keeps expected addr.
//  restart with 2 queued -> out_valid=0 next cycle; next word addr BASE_ADDR; err_seen kept.
//   rst instead -> err_seen=0.

Source files
------------

// File: rtl/instr_encode_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds the instruction format codes, the RV32I major opcodes and the field
// bundle passed to the combinational packer.
package instr_encode_pkg;

  // in_fmt codes; 6 and 7 are illegal
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_JAL   = 7'h6F;

  // Field tuple in decoder field order; imm is pre-shifted for B/J.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [19:0] imm;
  } enc_fields_t;

  function automatic logic fmt_legal(input logic [2:0] fmt);
    return fmt <= FMT_J;
  endfunction

endpackage

// File: rtl/instr_encode_pack.sv
// rv_enc_pack: pure combinational RV32I field -> instruction word packer.
// Ports:
//   fields_i  field tuple (format, opcode, registers, functs, immediate)
//   instr_o   packed 32-bit word; 0 for an illegal format
module rv_enc_pack
  import instr_encode_pkg::*;
(
  input  enc_fields_t fields_i,
  output logic [31:0] instr_o
);

  always_comb begin
    instr_o = '0;
    case (fields_i.fmt)
      FMT_R: instr_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
                        fields_i.rd, fields_i.opcode};
      FMT_I: instr_o = {fields_i.imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd,
                        fields_i.opcode};
      FMT_S: instr_o = {fields_i.imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                        fields_i.imm[4:0], fields_i.opcode};
      // imm holds branch offset[12:1]
      FMT_B: instr_o = {fields_i.imm[11], fields_i.imm[9:4], fields_i.rs2, fields_i.rs1,
                        fields_i.funct3, fields_i.imm[3:0], fields_i.imm[10], fields_i.opcode};
      FMT_U: instr_o = {fields_i.imm[19:0], fields_i.rd, fields_i.opcode};
      // imm holds jump offset[20:1]
      FMT_J: instr_o = {fields_i.imm[19], fields_i.imm[9:0], fields_i.imm[10],
                        fields_i.imm[18:11], fields_i.rd, fields_i.opcode};
      default: instr_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_encode.sv
// instr_encode: RV32I instruction encoder with address stamping and output FIFO.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   restart             flush FIFO and rewind the address counter to BASE_ADDR
//   in_*                valid/ready field tuple input (in_fmt 6/7 illegal)
//   out_valid/ready     FIFO head handshake; out_instr/out_addr are 0 when empty
//   err_pulse           one cycle after an illegal format was consumed
//   err_seen            sticky illegal-format flag, cleared only by rst
module instr_encode
  import instr_encode_pkg::*;
#(
  parameter int unsigned       DEPTH     = 2,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [19:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic              err_seen
);

  localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW    = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  enc_fields_t fields;
  logic [31:0] enc_word;

  assign fields.fmt    = in_fmt;
  assign fields.opcode = in_opcode;
  assign fields.rd     = in_rd;
  assign fields.rs1    = in_rs1;
  assign fields.rs2    = in_rs2;
  assign fields.funct3 = in_funct3;
  assign fields.funct7 = in_funct7;
  assign fields.imm    = in_imm;

  rv_enc_pack u_pack (
    .fields_i (fields),
    .instr_o  (enc_word)
  );

  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q  [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d  [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              err_pulse_q, err_pulse_d;
  logic              err_seen_q, err_seen_d;
  logic              accept, push, pop;

  always_comb begin
    // in_ready depends on registered count only, never on out_ready
    in_ready    = !rst && !restart && (count_q != CntFull);
    accept      = in_valid && in_ready;
    push        = accept && fmt_legal(in_fmt);
    out_valid   = (count_q != '0);
    pop         = out_valid && out_ready;

    instr_mem_d = instr_mem_q;
    addr_mem_d  = addr_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    next_addr_d = next_addr_q;

    if (restart) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      next_addr_d = BASE_ADDR;
    end else begin
      if (push) begin
        instr_mem_d[wr_ptr_q] = enc_word;
        addr_mem_d[wr_ptr_q]  = next_addr_q;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
        next_addr_d           = next_addr_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // accept is already 0 during restart, so only a pulse registered earlier fires
    err_pulse_d = accept && !fmt_legal(in_fmt);
    err_seen_d  = err_seen_q || err_pulse_d;

    out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    out_addr    = out_valid ? addr_mem_q[rd_ptr_q]  : '0;
    err_pulse   = err_pulse_q;
    err_seen    = err_seen_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      next_addr_q <= BASE_ADDR;
      err_pulse_q <= 1'b0;
      err_seen_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      next_addr_q <= next_addr_d;
      err_pulse_q <= err_pulse_d;
      err_seen_q  <= err_seen_d;
    end
  end

  // Storage needs no reset: entries are only visible behind count_q.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    addr_mem_q  <= addr_mem_d;
  end

endmodule
